// File: rtl/ksa_multiword_seq.sv
// rtl/ksa_multiword_seq.sv - adds WORDS*16-bit operands one limb per cycle through an external 16-bit adder
module ksa_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_s,
  input  logic [15:0]           add_c
);

  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [16*WORDS-1:0]   a_reg;
  logic [16*WORDS-1:0]   b_reg;
  logic                  carry_reg;

  // Only the limb carry-out is meaningful to the chain.
  logic unused_carries;
  assign unused_carries = ^add_c[14:0];

  always_comb begin
    add_a   = 16'h0;
    add_b   = 16'h0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[16*idx +: 16];
      add_b   = b_reg[16*idx +: 16];
      add_cin = carry_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
            sum       <= '0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum[16*idx +: 16] <= add_s;
          carry_reg         <= add_c[15];
          if (idx == LAST) begin
            // idx parks on the last limb so it never leaves 0..WORDS-1.
            cout      <= add_c[15];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ksa_multiword_seq.md
Name: ksa_multiword_seq

Overview:
- Sequencer that adds wide operands by feeding one 16-bit limb per cycle into an external 16-bit Kogge-Stone adder, and chaining the carry between limbs.
- Sits directly upstream and downstream of that adder:
  - drives its a/b/cin inputs;
  - consumes its s and carry vector (c[15] is the limb carry-out).
- Wide operands arrive and the result leaves over valid/ready handshakes.

Parameters:
- WORDS, 4, number of 16-bit limbs. Operand width is W = 16*WORDS. Legal range is 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operand request
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry into limb 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- sum  output  W  registered sum
- cout  output  1  registered carry out of the top limb
- add_a  output  16  limb of A to the adder
- add_b  output  16  limb of B to the adder
- add_cin  output  1  carry into the adder
- add_s  input  16  adder sum; combinational return within the same cycle
- add_c  input  16  adder carry vector; only add_c[15] is used

Behaviour:
- Reset (asynchronous, immediate on rst=1, including mid-operation):
  - state=IDLE; idx, a_reg, b_reg, carry_reg, sum and cout all 0.
  - out_valid=0; in_ready=1 once rst is released.
  - Any in-flight operation is discarded; nothing is emitted afterwards.
- States:
  - IDLE: in_ready=1.
    - On in_valid: latch a→a_reg, b→b_reg, cin→carry_reg; idx=0; sum cleared to 0; go to RUN.
  - RUN: in_ready=0. Adder drive each cycle:
    - add_a = a_reg[16*idx +: 16]
    - add_b = b_reg[16*idx +: 16]
    - add_cin = carry_reg
    - Each edge:
      - sum[16*idx +: 16] <= add_s
      - carry_reg <= add_c[15]
      - idx <= idx+1
    - On the edge where idx==WORDS-1: cout <= add_c[15] and go to DONE.
  - DONE: out_valid=1; sum and cout held stable.
    - On out_ready: go to IDLE and drop out_valid.
    - in_valid is ignored in DONE.
- Adder drive outside RUN: add_a, add_b and add_cin are 0.
- Latency:
  - Accept at edge k → out_valid high after edge k+WORDS.
  - Minimum issue interval is WORDS+2 cycles (RUN ×WORDS, DONE ×1, IDLE ×1).
- Backpressure: out_valid stays high with sum and cout unchanged until out_ready. A pending in_valid is not accepted and its operands are not sampled.
- Arithmetic: {cout,sum} = a + b + cin, exact, modulo 2^(W+1). No overflow flag; cout is the unsigned carry.
- idx width is ceil(log2(WORDS)). idx never exceeds WORDS-1 and resets to 0 on the IDLE→RUN transition.
- in_valid may drop without having been accepted (no hold requirement on the producer). Once accepted, input changes have no effect.

Test Plan (WORDS=4, adder model instantiated as the combinational return path):
- Ripple across all limbs:
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0.
  - Response: sum=0x0, cout=1, out_valid exactly 4 cycles after the accept edge.
- Per-limb carry isolation:
  - Stimulus: a=0x0123_4567_89AB_CDEF, b=0x1111_1111_1111_1111, cin=0.
  - Response: sum=0x1234_5678_9ABC_DF00, cout=0.
  - Also check add_a sequence = 0xCDEF, 0x89AB, 0x4567, 0x0123.
- Carry-in propagation:
  - Stimulus: a=0, b=0xFFFF_FFFF_FFFF_FFFF, cin=1.
  - Response: sum=0, cout=1; add_cin sequence = 1, 1, 1, 1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands present.
  - Response: out_valid, sum and cout stable; in_ready=0; new operands not accepted until one cycle after out_ready=1.
- Reset mid-RUN:
  - Stimulus: rst asserted after the second limb capture.
  - Response: sum=0, cout=0, out_valid=0 immediately; in_ready=1 after release; the next operation (5+7, cin=0) gives sum=12.
- Back-to-back:
  - Stimulus: in_valid and out_ready held high with 3 operand sets.
  - Response: three results in order, with accepts spaced 6 cycles apart.
